// File: rtl/cnt_hist_display.sv
// cnt_hist_display: samples a slow counter into a 4-deep hex history
// and scans that history onto a 4-digit common-anode seven-segment display.
module cnt_hist_display #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [3:0]  cnt_i,
   input  logic        clr_i,
   input  logic        hold_i,
   output logic [3:0]  an_o,
   output logic [6:0]  seg_o,
   output logic        dp_o,
   output logic        upd_o,
   output logic [15:0] hist_o
);
   // active-low {a,b,c,d,e,f,g}, indexed by hex digit
   localparam logic [6:0] FONT [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };
   logic [3:0]  s1_q, s2_q, prev_q;
   logic [15:0] hist_q, hist_d;
   logic        upd_q, upd_d;
   logic [16:0] rc_q, rc_d;
   logic [1:0]  sel_q, sel_d;
   logic [3:0]  an_q, an_d;
   logic [6:0]  seg_q, seg_d;
   logic        dp_q, dp_d;
   logic        change, cap, wrap;
   always_comb begin
      change = s2_q != prev_q;
      cap    = change & ~hold_i & ~clr_i;
      wrap   = rc_q == 17'(REFRESH_DIV - 1);
      hist_d = clr_i ? '0 : cap ? {hist_q[11:0], s2_q} : hist_q;
      upd_d  = cap;
      rc_d   = wrap ? '0 : rc_q + 17'd1;
      sel_d  = wrap ? sel_q + 2'd1 : sel_q;
      an_d   = ~(4'b0001 << sel_q);
      seg_d  = FONT[hist_q[4*sel_q +: 4]];
      dp_d   = sel_q != 2'd0;
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_q   <= '0;
         s2_q   <= '0;
         prev_q <= '0;
         hist_q <= '0;
         upd_q  <= 1'b0;
         rc_q   <= '0;
         sel_q  <= '0;
         an_q   <= 4'b1110;
         seg_q  <= 7'b0000001;
         dp_q   <= 1'b0;
      end else begin
         s1_q   <= cnt_i;
         s2_q   <= s1_q;
         prev_q <= s2_q;
         hist_q <= hist_d;
         upd_q  <= upd_d;
         rc_q   <= rc_d;
         sel_q  <= sel_d;
         an_q   <= an_d;
         seg_q  <= seg_d;
         dp_q   <= dp_d;
      end
   end
   assign an_o   = an_q;
   assign seg_o  = seg_q;
   assign dp_o   = dp_q;
   assign upd_o  = upd_q;
   assign hist_o = hist_q;
endmodule

// File: tb/tb_cnt_hist_display.sv
// tb_cnt_hist_display: directed bench for cnt_hist_display with REFRESH_DIV = 4;
// cnt and controls are driven on the falling edge, outputs sampled there too.
module tb_cnt_hist_display;
   logic        clk = 1'b0, rst = 1'b0, clr = 1'b0, hold = 1'b0;
   logic [3:0]  cnt = 4'd0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp, upd;
   logic [15:0] hist;
   int          n_chk = 0, n_err = 0;
   logic        seen, found;
   logic [3:0]  prev_an, an_exp;
   logic [6:0]  seg_tab [4] = '{7'b0001000, 7'b0000110, 7'b0010010, 7'b1001111};

   cnt_hist_display #(.REFRESH_DIV(4)) dut (
      .clk_i(clk), .rst_i(rst), .cnt_i(cnt), .clr_i(clr), .hold_i(hold),
      .an_o(an), .seg_o(seg), .dp_o(dp), .upd_o(upd), .hist_o(hist)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // drive a new value right after a falling edge and follow it through the pipeline
   task automatic cap(input logic [3:0] v, input logic [15:0] exp);
      cnt = v;
      @(negedge clk); chk("upd_e0", upd, 0);
      @(negedge clk); chk("upd_e1", upd, 0);
      @(negedge clk); chk("upd_e2", upd, 1); chk("hist_cap", hist, exp);
      @(negedge clk); chk("upd_e3", upd, 0);
      repeat (16) @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         seen = seen | upd;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_hist", hist, 16'h0000);
      chk("rst_upd", upd, 0);
      chk("rst_an", an, 4'b1110);
      chk("rst_seg", seg, 7'b0000001);
      chk("rst_dp", dp, 0);
      @(negedge clk) rst = 1'b0;
      seen = 1'b0;
      idle(4);
      chk("zero_nocap", seen, 0);
      cap(4'h1, 16'h0001);
      cap(4'h2, 16'h0012);
      cap(4'h3, 16'h0123);
      cap(4'hA, 16'h123A);
      found   = 1'b0;
      prev_an = an;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (an == 4'b1110 && prev_an != 4'b1110) found = 1'b1;
         prev_an = an;
      end
      chk("scan_sync", found, 1);
      for (int i = 0; i < 16; i++) begin
         an_exp = ~(4'b0001 << (i / 4));
         chk("scan_an", an, an_exp);
         chk("scan_seg", seg, seg_tab[i/4]);
         chk("scan_dp", dp, (i / 4) != 0);
         @(negedge clk);
      end
      hold = 1'b1;
      cnt  = 4'h5;
      seen = 1'b0;
      idle(6);
      hold = 1'b0;
      idle(6);
      chk("hold_upd", seen, 0);
      chk("hold_hist", hist, 16'h123A);
      cap(4'h6, 16'h23A6);
      cnt = 4'h7;
      @(negedge clk);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_hist", hist, 16'h0000);
      chk("clr_upd", upd, 0);
      seen = 1'b0;
      idle(4);
      chk("clr_after_upd", seen, 0);
      chk("clr_after_hist", hist, 16'h0000);
      cap(4'hE, 16'h000E);
      cap(4'hF, 16'h00EF);
      cap(4'h0, 16'h0EF0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_hist", hist, 16'h0000);
      chk("arst_an", an, 4'b1110);
      chk("arst_seg", seg, 7'b0000001);
      @(negedge clk) rst = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/cnt_hist_display.md
# cnt_hist_display

Display stage directly downstream of the 4-bit divided-clock binary counter. Samples the counter's `cnt` output in the fast system clock domain and records each new value into a 4-deep hex history. Time-multiplexes that history onto a 4-digit common-anode seven-segment display, so the last four counter values are visible at once. Also provides a capture pulse and the raw history word for LEDs or a testbench.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit. Legal range is 2..131071, held in a 17-bit refresh counter.
- `clk` in 1: system clock. This is the same undivided clock that feeds the counter's clock divider.
- `rst` in 1: reset, asynchronous and active-high. It clears every register in the block.
- `cnt` in 4: counter value. It changes on the divided clock edge, so it is asynchronous to the sampling logic here.
- `clr` in 1: synchronous history clear, active-high.
- `hold` in 1: freezes history capture, active-high.
- `an` out 4: digit anodes, active-low. `an[0]` is the rightmost (newest) digit.
- `seg` out 7: segment cathodes, active-low. Order is `{a,b,c,d,e,f,g}`, with `seg[6]` = a.
- `dp` out 1: decimal point, active-low. It is lit only on digit 0 to mark the newest value.
- `upd` out 1: one-cycle pulse, high in the cycle after a history capture.
- `hist` out 16: history word `{d3,d2,d1,d0}`, where d0 is the newest value.

## Operation
- **Synchronizer:** a 2-flop synchronizer `s1`→`s2` on `cnt`.
  - `prev` is loaded with `s2` on every clock edge.
  - `change` = (`s2` != `prev`).
- **Capture:** happens when `change & ~hold & ~clr`.
  - `hist` <= `{hist[11:0], s2}`.
  - `upd` <= 1 at the same edge. On all other edges `upd` <= 0.
- **Clear:** when `clr` = 1, `hist` <= 0 and `upd` <= 0.
  - `clr` beats a simultaneous change; that value is lost.
- **Hold:** while `hold` = 1, `prev` still tracks `s2`.
  - A change during hold is dropped, not queued.
  - Releasing hold captures nothing until the next change.
- **Refresh counter `rc`:** counts 0..REFRESH_DIV-1.
  - On the wrap edge, `rc` <= 0 and digit select `sel` <= `sel`+1 (mod 4, sequence 0→1→2→3→0).
  - `clr` and `hold` do not affect `rc` or `sel`.
- **Output registers:** `an`, `seg` and `dp` are registered from the current `sel` and `hist`.
  - `an` <= `~(4'b0001 << sel)`.
  - `seg` <= `font(hist[4*sel +: 4])`.
  - `dp` <= `(sel != 0)`.
- **Font:** standard hex, active-low `{a..g}`.
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111.
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- **Reset values:**
  - `s1`, `s2`, `prev`, `hist`, `rc`, `sel` = 0 and `upd` = 0.
  - `an` = 4'b1110, `seg` = 7'b0000001, `dp` = 0.
  - A `cnt` of 0 at reset release is not a change and is not captured.
- **Reset mid-operation:** asserting `rst` forces all reset values immediately, with no clock needed. Any in-flight sample in the synchronizer is discarded.

## Timing
- **Capture latency:** a `cnt` value stable before clock edge E0 is in `s1` after E0 and in `s2` after E1. `hist` and `upd` update at E2, and `upd` is high for exactly the cycle E2→E3.
- **Display latency:** `seg` reflects a new `hist` one edge later (E3), but only while its digit is selected.
- **Dwell:** each digit is lit for exactly REFRESH_DIV cycles, so the full scan period is 4·REFRESH_DIV cycles.
- **Digit switching:** `an`, `seg` and `dp` change on the same edge, one cycle after `sel` changes. No two anodes are ever low together.
- **Back-to-back changes:** two `cnt` changes on consecutive `clk` edges are both captured, one per cycle. In normal use the divided clock is far slower, so this never occurs.
- **Multi-bit transitions:** `cnt` is not Gray-coded. A multi-bit transition sampled mid-change may capture one transient value. This is accepted because `cnt` and the divider share the `clk` source and `cnt` changes just after a `clk` edge. The bench drives `cnt` on the negative edge.

## Test plan
Bench runs with REFRESH_DIV = 4 and drives `cnt` on the negative edge of `clk`.

- **Reset:** assert `rst` mid-cycle, then release. Required response: `hist` = 0000, `upd` = 0, `an` = 1110, `seg` = 0000001 and `dp` = 0, with no clock edge needed for the values to appear.
- **Capture sequence:** drive `cnt` 1, 2, 3, A, each held 20 cycles. Required response:
  - `hist` = 0x123A at the end.
  - One `upd` pulse per value, each asserted 2 edges after the change is sampled.
- **Scan:** with `hist` = 0x123A, observe 16 cycles. Required response:
  - `an` cycles 1110, 1101, 1011, 0111, each for 4 cycles.
  - `seg` shows 0001000 (A), 0000110 (3), 0010010 (2), 1001111 (1) in step with the anodes.
  - `dp` = 0 only while `an` = 1110.
- **Hold:** set `hold` = 1, change `cnt` to 5, then release `hold`. Required response: `hist` unchanged and no `upd`. A later change to 6 captures only 6.
- **Clear collision:** assert `clr` on the same cycle that a change reaches `s2`. Required response: `hist` = 0000, `upd` stays 0, and the next change captures normally.
- **Wrap:** drive `cnt` F→0 with `hist` = 0x00EF. Required response: `hist` = 0x0EF0, confirming that 0 is captured as a change.
